// File: rtl/c64_dma_pkg.sv
// Shared types and constants for the C64 expansion-port DMA arbiter.
// Holds the FSM state type, port indices and the round-robin pick helper.
package c64_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StOwn,
    StXfer,
    StNext
  } state_e;

  localparam int unsigned PORT_DEBUG  = 0;
  localparam int unsigned PORT_LOADER = 1;

  // Wide enough for MAX_BURST up to 15.
  localparam int unsigned BurstW = 4;

  // The port after `last` wins a tie; a lone requester always wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (last) begin
      return req[PORT_DEBUG] ? 1'b0 : 1'b1;
    end
    return req[PORT_LOADER] ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/phi2_edge_sync.sv
// Brings phi2 and BA into the color_clk domain and flags phi2 edges with
// registered single-cycle rise/fall pulses.
module phi2_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic color_clk,
  input  logic reset,
  input  logic phi2_i,
  input  logic ba_i,
  output logic rise_o,
  output logic fall_o,
  output logic ba_o
);

  logic [SYNC_STAGES-1:0] phi2_sync_q;
  logic [SYNC_STAGES-1:0] ba_sync_q;
  logic                   phi2_prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   phi2_s;

  assign phi2_s = phi2_sync_q[SYNC_STAGES-1];

  always_ff @(posedge color_clk) begin
    if (reset) begin
      phi2_sync_q <= '0;
      ba_sync_q   <= '0;
      phi2_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
    end else begin
      phi2_sync_q <= {phi2_sync_q[SYNC_STAGES-2:0], phi2_i};
      ba_sync_q   <= {ba_sync_q[SYNC_STAGES-2:0], ba_i};
      phi2_prev_q <= phi2_s;
      // Edge pulses appear the cycle after the last sync stage changes.
      rise_q      <= phi2_s & ~phi2_prev_q;
      fall_q      <= ~phi2_s & phi2_prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign ba_o   = ba_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/c64_dma_arbiter.sv
// Round-robin DMA master for the C64 expansion port: debug bridge (port 0)
// and PRG loader (port 1), one bus transfer per phi2 cycle while BA is high.
module c64_dma_arbiter
  import c64_dma_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 8,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          color_clk,
  input  logic          reset,
  input  logic          phi2_i,
  input  logic          ba_i,
  input  logic [DW-1:0] bus_rdata_i,
  output logic          dma_o,
  output logic [AW-1:0] addr_o,
  output logic          we_o,
  output logic [DW-1:0] wdata_o,
  input  logic [1:0]    req_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  output logic [1:0]    ack_o,
  output logic [DW-1:0] rdata_o
);

  localparam logic [BurstW-1:0] MaxBurstC = BurstW'(MAX_BURST);

  logic phi2_rise, phi2_fall, ba_sync;

  phi2_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .color_clk (color_clk),
    .reset     (reset),
    .phi2_i    (phi2_i),
    .ba_i      (ba_i),
    .rise_o    (phi2_rise),
    .fall_o    (phi2_fall),
    .ba_o      (ba_sync)
  );

  state_e              state_q, state_d;
  logic                winner_q, winner_d;
  logic                last_q, last_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic                dma_q, dma_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                we_q, we_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [1:0]          ack_q, ack_d;
  logic [DW-1:0]       rdata_q, rdata_d;

  logic                load_fields;
  logic                drive_sel;
  logic [1:0]          req_next;
  logic                pick_idle;
  logic                pick_next;

  // The port acked this cycle still shows its old request; ignore it here.
  assign req_next  = req_i & ~ack_q;
  assign pick_idle = rr_pick(req_i, last_q);
  assign pick_next = rr_pick(req_next, last_q);

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    last_d      = last_q;
    burst_d     = burst_q;
    dma_d       = dma_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    load_fields = 1'b0;
    drive_sel   = winner_q;

    unique case (state_q)
      StIdle: begin
        dma_d = 1'b0;
        if (|req_i) begin
          winner_d = pick_idle;
          state_d  = StArm;
        end
      end
      StArm: begin
        if (phi2_fall && ba_sync) begin
          dma_d       = 1'b1;
          load_fields = 1'b1;
          state_d     = StOwn;
        end
      end
      StOwn: begin
        // Losing BA before the transfer starts backs off and retries later.
        if (!ba_sync) begin
          dma_d   = 1'b0;
          state_d = StArm;
        end else if (phi2_rise) begin
          state_d = StXfer;
        end
      end
      StXfer: begin
        if (phi2_fall) begin
          rdata_d         = bus_rdata_i;
          ack_d[winner_q] = 1'b1;
          last_d          = winner_q;
          burst_d         = burst_q + BurstW'(1);
          state_d         = StNext;
        end
      end
      StNext: begin
        if (ba_sync && (burst_q < MaxBurstC) && (|req_next)) begin
          winner_d    = pick_next;
          drive_sel   = pick_next;
          load_fields = 1'b1;
          state_d     = StOwn;
        end else begin
          dma_d   = 1'b0;
          burst_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        dma_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    if (load_fields) begin
      addr_d  = drive_sel ? addr1_i  : addr0_i;
      we_d    = drive_sel ? we1_i    : we0_i;
      wdata_d = drive_sel ? wdata1_i : wdata0_i;
    end
  end

  always_ff @(posedge color_clk) begin
    if (reset) begin
      state_q  <= StIdle;
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      burst_q  <= '0;
      dma_q    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      dma_q    <= dma_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign dma_o   = dma_q;
  assign addr_o  = addr_q;
  assign we_o    = we_q;
  assign wdata_o = wdata_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;

  ack_onehot_a: assert property (@(posedge color_clk) disable iff (reset) !(&ack_q));

endmodule

// File: tb/tb_c64_dma_arbiter.sv
// Scoreboard bench for c64_dma_arbiter: per-port expected-transfer queues,
// a phi2-driven bus model and a monitor checking acks, fairness and tenures.
module tb_c64_dma_arbiter;

  localparam int unsigned AW          = 16;
  localparam int unsigned DW          = 8;
  localparam int unsigned MAX_BURST   = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic          color_clk = 1'b0;
  logic          reset     = 1'b1;
  logic          phi2      = 1'b0;
  logic          ba        = 1'b1;
  logic [DW-1:0] bus_rdata = '0;
  logic          dma;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [1:0]    req    = '0;
  logic [AW-1:0] addr0  = '0;
  logic [AW-1:0] addr1  = '0;
  logic          we0    = 1'b0;
  logic          we1    = 1'b0;
  logic [DW-1:0] wdata0 = '0;
  logic [DW-1:0] wdata1 = '0;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;

  c64_dma_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .MAX_BURST   (MAX_BURST),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .color_clk   (color_clk),
    .reset       (reset),
    .phi2_i      (phi2),
    .ba_i        (ba),
    .bus_rdata_i (bus_rdata),
    .dma_o       (dma),
    .addr_o      (addr),
    .we_o        (we),
    .wdata_o     (wdata),
    .req_i       (req),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .we0_i       (we0),
    .we1_i       (we1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .ack_o       (ack),
    .rdata_o     (rdata)
  );

  always #5 color_clk = ~color_clk;
  always #151 phi2 = ~phi2;

  typedef struct {
    logic [AW-1:0] a;
    logic          w;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t exp_q0[$];
  txn_t exp_q1[$];
  int   ack_log[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory-mapped read value seen on the C64 data bus for a given address.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (a == 16'hD020) return 8'h0E;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Bus side: the toplevel latches Do at every phi2 fall.
  logic [AW-1:0] snap_addr  = '0;
  logic          snap_we    = 1'b0;
  logic [DW-1:0] snap_wdata = '0;
  always @(negedge phi2) begin
    if (dma) begin
      snap_addr  = addr;
      snap_we    = we;
      snap_wdata = wdata;
    end
    bus_rdata = rd_model(addr);
  end

  // Monitor: pops the acked port's expected transfer and checks it.
  int         ack_total   = 0;
  int         tenure_acks = 0;
  int         last_tenure = 0;
  int         max_tenure  = 0;
  int         last_port   = -1;
  logic [1:0] waiting     = '0;
  logic       dma_prev    = 1'b0;

  always @(negedge color_clk) begin
    txn_t t;
    if (reset) begin
      waiting     = '0;
      last_port   = -1;
      tenure_acks = 0;
      dma_prev    = 1'b0;
    end else begin
      waiting = waiting & req;
      if (dma && !dma_prev) tenure_acks = 0;
      if (ack != 2'b00) begin
        check("ack_onehot", 32'(ack != 2'b11), 32'd1);
        for (int p = 0; p < 2; p++) begin
          if (ack[p]) begin
            if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_ack: port %0d acked with nothing outstanding", p);
            end else begin
              t = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              check("bus_addr", 32'(snap_addr), 32'(t.a));
              check("bus_we", 32'(snap_we), 32'(t.w));
              if (t.w) check("bus_wdata", 32'(snap_wdata), 32'(t.d));
              else     check("rdata", 32'(rdata), 32'(t.rd));
            end
            if (last_port == p && waiting[1-p]) begin
              n_checks++;
              n_fail++;
              $display("FAIL round_robin: port %0d acked twice while port %0d waited", p, 1 - p);
            end
            waiting[1-p] = req[1-p];
            last_port    = p;
            ack_total++;
            tenure_acks++;
            ack_log.push_back(p);
          end
        end
      end
      if (!dma && dma_prev) begin
        check("tenure_le_max_burst", 32'(tenure_acks <= MAX_BURST), 32'd1);
        last_tenure = tenure_acks;
        if (tenure_acks > max_tenure) max_tenure = tenure_acks;
      end
      dma_prev = dma;
    end
  end

  // Requester: hold fields until ack, then update/drop in the following cycle.
  task automatic issue(input int p, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input bit drop);
    txn_t t;
    int   n;
    t.a  = a;
    t.w  = w;
    t.d  = d;
    t.rd = rd_model(a);
    if (p == 0) begin
      addr0 = a; we0 = w; wdata0 = d; exp_q0.push_back(t);
    end else begin
      addr1 = a; we1 = w; wdata1 = d; exp_q1.push_back(t);
    end
    req[p] = 1'b1;
    n = 0;
    do begin
      @(posedge color_clk); #1;
      n++;
    end while (!ack[p] && n < 4000);
    if (!ack[p]) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: port %0d addr %0h never acked", p, a);
    end
    @(posedge color_clk); #1;
    if (drop) req[p] = 1'b0;
  endtask

  task automatic wait_dma(input logic level, input string name);
    int n = 0;
    while (dma !== level && n < 400) begin
      @(posedge color_clk); #1;
      n++;
    end
    check(name, 32'(dma), 32'(level));
  endtask

  task automatic wait_acks(input int target, input string name);
    int n = 0;
    while (ack_total < target && n < 3000) begin
      @(posedge color_clk); #1;
      n++;
    end
    check(name, 32'(ack_total), 32'(target));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_dma"}, 32'(dma), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_we"}, 32'(we), 32'd0);
    check({tag, "_wdata"}, 32'(wdata), 32'd0);
    check({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    repeat (4) @(posedge color_clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (20) @(posedge color_clk);

    // Single read: dma rises at the first fall, ack follows the second fall.
    @(posedge phi2);
    repeat (2) @(posedge color_clk);
    #1;
    base = ack_total;
    fork
      issue(0, 16'hD020, 1'b0, 8'h00, 1'b1);
      begin
        @(negedge phi2);
        check("single_dma_low_at_fall1", 32'(dma), 32'd0);
        @(posedge phi2);
        check("single_dma_high_after_fall1", 32'(dma), 32'd1);
        @(negedge phi2);
        check("single_no_ack_before_fall2", 32'(ack_total), 32'(base));
        repeat (8) @(posedge color_clk);
        #1;
        check("single_ack_after_fall2", 32'(ack_total), 32'(base + 1));
        check("single_rdata", 32'(rdata), 32'h0E);
        @(posedge phi2);
        check("single_dma_released", 32'(dma), 32'd0);
      end
    join

    // Simultaneous requests right after reset: port 0 first, one tenure.
    reset = 1'b1;
    repeat (2) @(posedge color_clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge color_clk);
    @(posedge phi2);
    #1;
    ack_log.delete();
    fork
      issue(0, 16'h0400, 1'b0, 8'h00, 1'b1);
      issue(1, 16'h1234, 1'b1, 8'h5C, 1'b1);
    join
    wait_dma(1'b0, "simul_dma_release");
    repeat (4) @(posedge color_clk);
    #1;
    check("simul_ack_count", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() > 0) check("simul_first_port", 32'(ack_log[0]), 32'd0);
    check("simul_one_tenure", 32'(last_tenure), 32'd2);

    // Loader alone: six back-to-back writes.
    base = ack_total;
    for (int i = 0; i < 6; i++) begin
      issue(1, AW'(16'h2000 + i), 1'b1, 8'($urandom()), i == 5);
    end
    check("loader_six_acks", 32'(ack_total), 32'(base + 6));

    // Both ports saturating: tenures are capped at MAX_BURST.
    repeat (40) @(posedge color_clk);
    max_tenure = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          issue(0, AW'($urandom_range(16'h7FFF, 0)), 1'b0, 8'h00, i == 5);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          issue(1, AW'($urandom_range(16'hFFFF, 16'h8000)), 1'b1, 8'($urandom()), i == 5);
        end
      end
    join
    wait_dma(1'b0, "sat_dma_release");
    repeat (4) @(posedge color_clk);
    #1;
    check("sat_max_tenure", 32'(max_tenure), 32'(MAX_BURST));

    // BA low while armed: no DMA for three phi2 cycles.
    repeat (40) @(posedge color_clk);
    #1;
    ba   = 1'b0;
    base = ack_total;
    repeat (5) @(posedge color_clk);
    #1;
    fork
      issue(0, 16'hC000, 1'b0, 8'h00, 1'b1);
    join_none
    for (int i = 0; i < 3; i++) begin
      @(negedge phi2);
      check("ba_stall_dma_low", 32'(dma), 32'd0);
    end
    @(posedge phi2);
    ba = 1'b1;
    @(negedge phi2);
    check("ba_no_early_ack", 32'(ack_total), 32'(base));
    @(negedge phi2);
    repeat (8) @(posedge color_clk);
    #1;
    check("ba_resume_ack", 32'(ack_total), 32'(base + 1));
    repeat (40) @(posedge color_clk);

    // BA drops while owning the bus: release, no ack, retry same address.
    #1;
    base = ack_total;
    fork
      issue(1, 16'hBEEF, 1'b0, 8'h00, 1'b1);
    join_none
    wait_dma(1'b1, "own_dma_taken");
    ba = 1'b0;
    repeat (6) @(posedge color_clk);
    #1;
    check("own_ba_drop_dma", 32'(dma), 32'd0);
    check("own_ba_drop_no_ack", 32'(ack_total), 32'(base));
    @(posedge phi2);
    @(posedge phi2);
    ba = 1'b1;
    wait_acks(base + 1, "own_retry_ack");
    repeat (40) @(posedge color_clk);

    // Reset in the middle of a transfer.
    #1;
    base = ack_total;
    fork
      issue(0, 16'h0801, 1'b1, 8'hA7, 1'b1);
    join_none
    wait_dma(1'b1, "rst_dma_taken");
    @(posedge phi2);
    repeat (6) @(posedge color_clk);
    #1;
    reset = 1'b1;
    @(posedge color_clk);
    #1;
    check_outputs_zero("rst_mid");
    check("rst_no_ack", 32'(ack_total), 32'(base));
    reset = 1'b0;
    @(negedge phi2);
    repeat (8) @(posedge color_clk);
    #1;
    check("rst_no_ack_at_fall", 32'(ack_total), 32'(base));
    wait_acks(base + 1, "rst_recover_ack");
    repeat (40) @(posedge color_clk);

    check("all_expected_drained", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/c64_dma_arbiter.md
# c64_dma_arbiter

Bus-master arbiter that shares the C64 expansion-port DMA path between two requesters: the UART debug bridge (port 0) and a PRG/cartridge loader (port 1). It runs in the `color_clk` domain and synchronises `phi2` internally. It asserts `DMA` only on cycles the VIC leaves free (`BA`=1), sequences one bus transfer per `phi2` cycle, and returns read data with a single-cycle ack. It sits between the requesters and the `c64` core's `DMA`/`Ai`/`Di`/`RW` inputs, replacing the ad-hoc debug DMA logic in the board toplevel.

## Interface
Parameters:
- `AW`, 16: bus address width
- `DW`, 8: bus data width
- `MAX_BURST`, 4: maximum transfers per DMA tenure (1..15)
- `SYNC_STAGES`, 2: `phi2`/`BA` synchroniser depth (≥2)

Ports:
- `color_clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `phi2_i`  in  1  CPU phase-2 clock, asynchronous to `color_clk`
- `ba_i`  in  1  VIC bus-available, asynchronous
- `bus_rdata_i`  in  DW  C64 `Do`, latched at `phi2` falling edge by the toplevel; stable for a full `phi2` period
- `dma_o`  out  1  to c64 `DMA`
- `addr_o`  out  AW  to c64 `Ai`
- `we_o`  out  1  to c64 `RW` (1 = write)
- `wdata_o`  out  DW  to c64 `Di`
- `req_i`  in  2  per-port request, level
- `addr0_i`, `addr1_i`  in  AW  per-port address
- `we0_i`, `we1_i`  in  1  per-port write enable
- `wdata0_i`, `wdata1_i`  in  DW  per-port write data
- `ack_o`  out  2  per-port one-cycle completion pulse
- `rdata_o`  out  DW  read data, valid in the `ack_o` cycle

## Operation
- Requester protocol: hold `req`/addr/we/wdata stable from assertion until the `ack` cycle. Drop `req` or change fields in the cycle after `ack`. The arbiter does not check for protocol violations.
- Arbitration: round-robin. The `last` pointer resets to 1, so port 0 wins the first tie. The grant is evaluated only in `IDLE` and at burst continuation.
- States:
  - `IDLE`: `dma_o`=0. If any `req`, latch the winner index → `ARM`.
  - `ARM`: on a synced `phi2` fall with synced `ba`=1, set `dma_o`=1 and drive the winner's fields → `OWN`. If `ba`=0, stay in `ARM`.
  - `OWN`: on a synced `phi2` rise → `XFER`. If synced `ba` falls in this state, clear `dma_o` → `ARM`, keeping the same winner and issuing no ack.
  - `XFER`: on a synced `phi2` fall, capture `bus_rdata_i` into `rdata_o`, pulse `ack_o[winner]`, set `last`=winner, increment the burst count → `NEXT`.
  - `NEXT` (1 cycle): if synced `ba`=1, burst count < `MAX_BURST`, and any `req` is pending (excluding the just-acked port's stale `req` in this cycle), pick the round-robin winner and drive its fields with `dma_o` held → `OWN`. Otherwise clear `dma_o`, zero the burst count → `IDLE`.
- Bus outputs hold their last driven values when `dma_o`=0. They are don't-care to the core.
- Write data is driven for the entire `phi2`-high phase of the transfer.
- Reset, including mid-transfer: next edge sets `dma_o`=0, `ack_o`=0, `addr_o`=0, `we_o`=0, `wdata_o`=0, `rdata_o`=0, state `IDLE`, burst count 0, `last`=1. An interrupted transfer is never acked.

## Timing
- Edge detect: `phi2` fall/rise is flagged the cycle after sync stage `SYNC_STAGES` changes. That is a latency of `SYNC_STAGES`+1 `color_clk` cycles, about 85 ns at 35.47 MHz, well inside the roughly 507 ns half-period.
- `dma_o` rises at the registered output 1 cycle after the fall detect in `ARM`.
- `ack_o` pulses exactly 1 `color_clk` cycle, 1 cycle after the `XFER` fall detect. `rdata_o` is valid in that cycle and held until the next ack.
- Minimum single-transfer latency, from `req` to `ack`: 2 `phi2` falls after the `req` is registered.
- Burst throughput: 1 transfer per `phi2` cycle.

## Structure
- Package `c64_dma_pkg`:
  - state enum (`IDLE`, `ARM`, `OWN`, `XFER`, `NEXT`)
  - port index constants (`PORT_DEBUG`=0, `PORT_LOADER`=1)
  - `MAX_BURST` counter width
- Sub-module `phi2_edge_sync`: `SYNC_STAGES`-deep synchroniser for `phi2` and `ba`, with registered `rise`/`fall` pulses and the synced `ba` level.
- Arbiter FSM and output muxing live in `c64_dma_arbiter`.

## Test plan
- Single read: port 0 requests addr `16'hD020`, `bus_rdata_i`=`8'h0E`, `ba`=1. Expect `dma_o`=1 on the fall after `ARM`, then `ack_o`=`2'b01` with `rdata_o`=`8'h0E` on the next fall, then `dma_o`=0.
- Simultaneous requests after reset: both ports request. Port 0 is acked first, port 1 in the same tenure on the next `phi2` cycle. Two acks total, `dma_o` continuous.
- Burst limit: port 1 holds `req` for 6 writes with `MAX_BURST`=4. Expect 4 acks, `dma_o` low for at least one `phi2` fall, then 2 more acks.
- BA stall: `ba`=0 while in `ARM` for 3 `phi2` cycles. `dma_o` stays 0. Transfer completes 1 `phi2` cycle after `ba` returns high. `ba` falling in `OWN` gives `dma_o`=0, no ack, and a retry of the same address.
- Reset mid-`XFER`: all outputs are 0 on the next cycle, no `ack_o` is pulsed, and a subsequent request completes normally.
